// File: rtl/line3_buffer.sv
// Three-row sliding line buffer: keeps the last three accepted rows as a vertical
// window and pulses valid_o when a window lying entirely within one frame is due.
module line3_buffer #(
   parameter  int DATA_BITS = 8,
   parameter  int D         = 1,
   parameter  int H         = 24,
   parameter  int W         = 24,
   parameter  int K         = 6,
   localparam int ROW_BITS  = W * DATA_BITS * K
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [ROW_BITS-1:0] input_data,
   input  logic                valid_i,
   output logic [ROW_BITS-1:0] output_1,
   output logic [ROW_BITS-1:0] output_2,
   output logic [ROW_BITS-1:0] output_3,
   output logic                valid_o
);

   localparam int CNT_W = (H > 1) ? $clog2(H + 1) : 1;
   localparam int STR_W = (D > 1) ? $clog2(D + 1) : 1;

   logic [ROW_BITS-1:0] out1_q, out1_d;
   logic [ROW_BITS-1:0] out2_q, out2_d;
   logic [ROW_BITS-1:0] out3_q, out3_d;
   logic                vld_q, vld_d;
   logic [1:0]          fill_q, fill_d;
   logic [CNT_W-1:0]    row_q, row_d;
   logic [STR_W-1:0]    stride_q, stride_d;

   function automatic logic [STR_W-1:0] stride_next(input logic [STR_W-1:0] s);
      if (s == STR_W'(D - 1)) return '0;
      return s + STR_W'(1);
   endfunction

   always_comb begin
      out1_d   = out1_q;
      out2_d   = out2_q;
      out3_d   = out3_q;
      vld_d    = 1'b0;
      fill_d   = fill_q;
      row_d    = row_q;
      stride_d = stride_q;
      if (valid_i) begin
         out1_d = out2_q;
         out2_d = out3_q;
         out3_d = input_data;
         // Stride count stays 0 until priming, so the first window of a frame always emits.
         if (fill_q >= 2'd2) begin
            vld_d    = (stride_q == '0);
            stride_d = stride_next(stride_q);
         end
         fill_d = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
         // Last row of the frame: the window may still emit, then the frame state restarts.
         if (row_q == CNT_W'(H - 1)) begin
            row_d    = '0;
            fill_d   = '0;
            stride_d = '0;
         end else begin
            row_d = row_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         out1_q   <= '0;
         out2_q   <= '0;
         out3_q   <= '0;
         vld_q    <= 1'b0;
         fill_q   <= '0;
         row_q    <= '0;
         stride_q <= '0;
      end else begin
         out1_q   <= out1_d;
         out2_q   <= out2_d;
         out3_q   <= out3_d;
         vld_q    <= vld_d;
         fill_q   <= fill_d;
         row_q    <= row_d;
         stride_q <= stride_d;
      end
   end

   assign output_1 = out1_q;
   assign output_2 = out2_q;
   assign output_3 = out3_q;
   assign valid_o  = vld_q;

endmodule

// File: tb/tb_line3_buffer.sv
// Directed bench for line3_buffer: default instance plus H=4 and D=2 variants on shared stimulus.
module tb_line3_buffer;

   localparam int RB = 24 * 8 * 6;

   logic          clk = 1'b0;
   logic          resetn;
   logic          valid_i;
   logic [RB-1:0] input_data;

   logic [RB-1:0] o1_a, o2_a, o3_a, o1_h, o2_h, o3_h, o1_s, o2_s, o3_s;
   logic          v_a, v_h, v_s;

   int n_tests = 0;
   int n_fail  = 0;

   line3_buffer dut_a (
      .clk(clk), .resetn(resetn), .input_data(input_data), .valid_i(valid_i),
      .output_1(o1_a), .output_2(o2_a), .output_3(o3_a), .valid_o(v_a)
   );

   line3_buffer #(.H(4)) dut_h (
      .clk(clk), .resetn(resetn), .input_data(input_data), .valid_i(valid_i),
      .output_1(o1_h), .output_2(o2_h), .output_3(o3_h), .valid_o(v_h)
   );

   line3_buffer #(.D(2)) dut_s (
      .clk(clk), .resetn(resetn), .input_data(input_data), .valid_i(valid_i),
      .output_1(o1_s), .output_2(o2_s), .output_3(o3_s), .valid_o(v_s)
   );

   always #5 clk = ~clk;

   function automatic logic [RB-1:0] rep(input logic [7:0] b);
      return {(RB / 8){b}};
   endfunction

   task automatic check(input string tag, input logic [RB-1:0] act, input logic [RB-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h (low 32b) expected %h (low 32b)", tag, act[31:0], exp[31:0]);
      end
   endtask

   task automatic accept(input logic [7:0] b);
      valid_i    = 1'b1;
      input_data = rep(b);
      @(posedge clk);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic idle();
      valid_i = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn  = 1'b1;
      valid_i = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b0;
   endtask

   task automatic check_win(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c);
      check({tag, "_o1"}, o1_a, rep(a));
      check({tag, "_o2"}, o2_a, rep(b));
      check({tag, "_o3"}, o3_a, rep(c));
   endtask

   logic [6:0] exp_h;
   logic [5:0] exp_s;

   initial begin
      resetn     = 1'b1;
      valid_i    = 1'b1;
      input_data = rep(8'hFF);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_o1", o1_a, '0);
      check("rst_o2", o2_a, '0);
      check("rst_o3", o3_a, '0);
      check("rst_vld", RB'(v_a), RB'(0));
      resetn  = 1'b0;
      valid_i = 1'b0;
      idle();

      // Fill with idle gaps
      accept(8'hA1); check("fill_a_vld", RB'(v_a), RB'(0));
      idle();        check("fill_a_idle_vld", RB'(v_a), RB'(0));
      accept(8'hB1); check("fill_b_vld", RB'(v_a), RB'(0));
      idle();
      accept(8'hC1); check("fill_c_vld", RB'(v_a), RB'(1));
      check_win("fill_c", 8'hA1, 8'hB1, 8'hC1);
      idle();        check("fill_idle_vld", RB'(v_a), RB'(0));
      check_win("fill_hold", 8'hA1, 8'hB1, 8'hC1);
      idle();        check_win("fill_hold2", 8'hA1, 8'hB1, 8'hC1);

      // Slide
      accept(8'hA1); check("slide1_vld", RB'(v_a), RB'(1));
      check_win("slide1", 8'hB1, 8'hC1, 8'hA1);
      accept(8'hB1); check("slide2_vld", RB'(v_a), RB'(1));
      check_win("slide2", 8'hC1, 8'hA1, 8'hB1);
      accept(8'hC1); check("slide3_vld", RB'(v_a), RB'(1));
      check_win("slide3", 8'hA1, 8'hB1, 8'hC1);
      idle();        check("slide_idle_vld", RB'(v_a), RB'(0));

      // Frame wrap, H=4: R0..R6 back to back
      do_reset();
      exp_h = 7'b1001100;
      for (int i = 0; i < 7; i++) begin
         accept(8'h10 + 8'(i));
         check($sformatf("wrap_r%0d_vld", i), RB'(v_h), RB'(exp_h[i]));
         if (i == 3) begin
            check("wrap_r3_o1", o1_h, rep(8'h11));
            check("wrap_r3_o3", o3_h, rep(8'h13));
         end
      end
      check("wrap_r6_o1", o1_h, rep(8'h14));
      check("wrap_r6_o2", o2_h, rep(8'h15));
      check("wrap_r6_o3", o3_h, rep(8'h16));

      // Stride, D=2: six rows back to back; default instance emits on every primed row
      do_reset();
      exp_s = 6'b010100;
      for (int i = 0; i < 6; i++) begin
         accept(8'h20 + 8'(i));
         check($sformatf("stride_r%0d_vld", i + 1), RB'(v_s), RB'(exp_s[i]));
         check($sformatf("d1_r%0d_vld", i + 1), RB'(v_a), RB'(i >= 2));
      end
      idle();
      check("stride_idle_vld", RB'(v_s), RB'(0));

      // Mid-operation reset
      do_reset();
      accept(8'h31);
      accept(8'h32);
      do_reset();
      check("mid_rst_o3", o3_a, '0);
      check("mid_rst_vld", RB'(v_a), RB'(0));
      accept(8'h33); check("mid_r1_vld", RB'(v_a), RB'(0));
      accept(8'h34); check("mid_r2_vld", RB'(v_a), RB'(0));
      accept(8'h35); check("mid_r3_vld", RB'(v_a), RB'(1));
      check("mid_r3_o1", o1_a, rep(8'h33));
      check("mid_r3_o3", o3_a, rep(8'h35));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
